// File: rtl/sw_out_arbiter.sv
// sw_out_arbiter: per-output switch allocator with round-robin heads, per-VC credits and wormhole locking
module sw_out_arbiter #(
    parameter int PORT_N    = 5,
    parameter int VCH_N     = 2,
    parameter int BUF_DEPTH = 4,
    parameter int VCH_W     = $clog2(VCH_N),
    parameter int CRD_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_N-1:0]         req_i,
    input  logic [PORT_N*VCH_W-1:0]   req_vch_i,
    input  logic [PORT_N-1:0]         head_i,
    input  logic [PORT_N-1:0]         tail_i,
    input  logic [VCH_N-1:0]          credit_i,
    output logic [PORT_N-1:0]         sel_o,
    output logic                      busy_o,
    output logic                      crd_err_o
);
    localparam int PTR_W = $clog2(PORT_N);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d, owner_q, owner_d, win_idx, cur_idx;
    logic [VCH_W-1:0]  lock_vch_q, lock_vch_d, fire_vch;
    logic [CRD_W-1:0]  crd_q [VCH_N];
    logic [CRD_W-1:0]  crd_d [VCH_N];
    logic              crd_err_q, crd_err_d;
    logic [PORT_N-1:0] elig, sel;
    logic              win_found, fire, fire_v;
    int                c;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PORT_N - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < PORT_N; i++)
            elig[i] = req_i[i] && (crd_q[req_vch_i[i*VCH_W +: VCH_W]] != '0);
    end

    // first eligible head at or after rr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        c         = 0;
        for (int k = 0; k < PORT_N; k++) begin
            c = (int'(rr_q) + k) % PORT_N;
            if (!win_found && elig[c] && head_i[c]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(c);
            end
        end
    end

    always_comb begin
        cur_idx    = (state_q == LOCKED) ? owner_q : win_idx;
        fire_vch   = (state_q == LOCKED) ? lock_vch_q : req_vch_i[cur_idx*VCH_W +: VCH_W];
        fire       = rst_n && ((state_q == LOCKED) ? (req_i[owner_q] && crd_q[lock_vch_q] != '0) : win_found);
        sel        = fire ? (PORT_N'(1) << cur_idx) : '0;
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        lock_vch_d = lock_vch_q;
        crd_err_d  = crd_err_q;
        fire_v     = 1'b0;
        if (fire && tail_i[cur_idx]) begin
            state_d = IDLE;
            rr_d    = nxt(cur_idx);
        end else if (fire && state_q == IDLE) begin
            state_d    = LOCKED;
            owner_d    = cur_idx;
            lock_vch_d = fire_vch;
        end
        for (int v = 0; v < VCH_N; v++) begin
            fire_v   = fire && (fire_vch == VCH_W'(v));
            crd_d[v] = crd_q[v];
            if (fire_v && !credit_i[v])
                crd_d[v] = crd_q[v] - 1'b1;
            else if (!fire_v && credit_i[v] && crd_q[v] == CRD_W'(BUF_DEPTH))
                crd_err_d = 1'b1;
            else if (!fire_v && credit_i[v])
                crd_d[v] = crd_q[v] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            lock_vch_q <= '0;
            crd_err_q  <= 1'b0;
            for (int v = 0; v < VCH_N; v++)
                crd_q[v] <= CRD_W'(BUF_DEPTH);
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            lock_vch_q <= lock_vch_d;
            crd_err_q  <= crd_err_d;
            for (int v = 0; v < VCH_N; v++)
                crd_q[v] <= crd_d[v];
        end
    end

    assign sel_o     = sel;
    assign busy_o    = (state_q == LOCKED);
    assign crd_err_o = crd_err_q;
endmodule

// File: tb/tb_sw_out_arbiter.sv
// tb_sw_out_arbiter: directed scoreboard bench for the output switch allocator
module tb_sw_out_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req, vch, head, tail, sel;
    logic [1:0] cr;
    logic       busy, err;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic [4:0] sel;
        logic       busy;
        logic       err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sw_out_arbiter #(.PORT_N(5), .VCH_N(2), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_vch_i(vch), .head_i(head),
        .tail_i(tail), .credit_i(cr), .sel_o(sel), .busy_o(busy), .crd_err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle at negedge, compare combinational and registered outputs, advance
    task automatic cyc(input logic r, input logic [4:0] q, input logic [4:0] v, input logic [4:0] h,
                       input logic [4:0] t, input logic [1:0] c,
                       input logic [4:0] es, input logic eb, input logic ee);
        exp_t e;
        rst_n = r; req = q; vch = v; head = h; tail = t; cr = c;
        sb.push_back('{sel: es, busy: eb, err: ee});
        #1;
        e = sb.pop_front();
        chk("sel", 32'(sel), 32'(e.sel));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("crd_err", 32'(err), 32'(e.err));
        @(negedge clk);
    endtask

    task automatic chk_state(input int rr, input int c0, input int c1);
        chk("rr", 32'(dut.rr_q), 32'(rr));
        chk("credit0", 32'(dut.crd_q[0]), 32'(c0));
        chk("credit1", 32'(dut.crd_q[1]), 32'(c1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; vch = '0; head = '0; tail = '0; cr = '0;
        @(negedge clk);
        cyc(0, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 2'b00, 5'b00000, 0, 0);
        chk_state(0, 4, 4);
        // single-flit from input 2
        cyc(1, 5'b00100, 5'b00000, 5'b00100, 5'b00100, 2'b00, 5'b00100, 0, 0);
        chk_state(3, 3, 4);
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 0, 0);
        chk_state(0, 4, 4);
        // round robin among 0,1,3 with fire+return on VC0
        cyc(1, 5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b01, 5'b00001, 0, 0);
        cyc(1, 5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b01, 5'b00010, 0, 0);
        cyc(1, 5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b01, 5'b01000, 0, 0);
        cyc(1, 5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b01, 5'b00001, 0, 0);
        cyc(1, 5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b01, 5'b00010, 0, 0);
        cyc(1, 5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b01, 5'b01000, 0, 0);
        chk_state(4, 4, 4);
        cyc(1, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 2'b01, 5'b00001, 0, 0);
        chk_state(1, 4, 4);
        // 3-flit packet from input 1 on VC1 while input 4 waits
        cyc(1, 5'b10010, 5'b00010, 5'b10010, 5'b10000, 2'b00, 5'b00010, 0, 0);
        cyc(1, 5'b10010, 5'b00010, 5'b10000, 5'b10000, 2'b00, 5'b00010, 1, 0);
        cyc(1, 5'b10010, 5'b00010, 5'b10000, 5'b10010, 2'b00, 5'b00010, 1, 0);
        chk_state(2, 4, 1);
        cyc(1, 5'b10000, 5'b00000, 5'b10000, 5'b10000, 2'b00, 5'b10000, 0, 0);
        chk_state(0, 3, 1);
        // input 2 locks VC0 and drains it; stall, then credit pulses release flits
        cyc(1, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 2'b00, 5'b00100, 0, 0);
        cyc(1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00100, 1, 0);
        cyc(1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00100, 1, 0);
        cyc(1, 5'b00101, 5'b00001, 5'b00001, 5'b00001, 2'b00, 5'b00000, 1, 0);
        cyc(1, 5'b00101, 5'b00001, 5'b00001, 5'b00001, 2'b01, 5'b00000, 1, 0);
        chk_state(0, 1, 1);
        cyc(1, 5'b00101, 5'b00001, 5'b00001, 5'b00001, 2'b00, 5'b00100, 1, 0);
        cyc(1, 5'b00101, 5'b00001, 5'b00001, 5'b00101, 2'b01, 5'b00000, 1, 0);
        cyc(1, 5'b00101, 5'b00001, 5'b00001, 5'b00101, 2'b00, 5'b00100, 1, 0);
        cyc(1, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 2'b00, 5'b00001, 0, 0);
        chk_state(1, 0, 0);
        // no credit on VC1 for input 0, non-head from input 1: nothing granted
        cyc(1, 5'b00011, 5'b00001, 5'b00001, 5'b00011, 2'b00, 5'b00000, 0, 0);
        repeat (4) cyc(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 0, 0);
        chk_state(1, 4, 4);
        // overflow on VC1, then fire+return at full count
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b10, 5'b00000, 0, 0);
        chk_state(1, 4, 4);
        cyc(1, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 2'b10, 5'b01000, 0, 1);
        chk_state(4, 4, 4);
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 0, 1);
        // reset in the middle of a locked packet from input 3
        cyc(1, 5'b01000, 5'b00000, 5'b01000, 5'b00000, 2'b00, 5'b01000, 0, 1);
        cyc(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b01000, 1, 1);
        cyc(0, 5'b01010, 5'b00000, 5'b00010, 5'b00010, 2'b00, 5'b00000, 1, 1);
        chk_state(0, 4, 4);
        cyc(1, 5'b01010, 5'b00000, 5'b00010, 5'b00010, 2'b00, 5'b00010, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
